ghost_motion: RTL and testbench

- Per-ghost position and direction controller, one instance per ghost (red, blue, yellow, pink).
- Sits directly upstream of the enemy sprite renderer and drives its 9-bit x/y inputs.
- Steps the ghost one pixel per movement tick. At each tile-aligned position it picks a new direction toward a target tile, querying the maze wall map over a req/ack handshake.

---
 rtl/ghost_pkg.sv | 31 +++
 rtl/ghost_dist_sq.sv | 26 ++
 rtl/ghost_motion.sv | 240 ++++++++++++++++++++++++
 tb/tb_ghost_motion.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost motion controller.
// Tunnel wrap is selected by the GHOST_WRAP_TUNNEL_EN macro.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        QUERY  = 2'd1,
        DECIDE = 2'd2,
        MOVE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       oob;
        logic [5:0] tx;
        logic [5:0] ty;
    } tile_t;

    localparam int TILE_SHIFT = 3;

    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/ghost_dist_sq.sv
// Squared euclidean distance between two 6-bit tile coordinates.
// Combinational; result fits 13 bits unsigned.
module ghost_dist_sq (
    input  logic [5:0]  ax_i,
    input  logic [5:0]  ay_i,
    input  logic [5:0]  bx_i,
    input  logic [5:0]  by_i,
    output logic [12:0] d_o
);

    logic signed [6:0]  dx;
    logic signed [6:0]  dy;
    logic signed [12:0] ex;
    logic signed [12:0] ey;
    logic signed [12:0] px;
    logic signed [12:0] py;

    assign dx = $signed({1'b0, ax_i}) - $signed({1'b0, bx_i});
    assign dy = $signed({1'b0, ay_i}) - $signed({1'b0, by_i});
    assign ex = {{6{dx[6]}}, dx};
    assign ey = {{6{dy[6]}}, dy};
    assign px = ex * ex;
    assign py = ey * ey;
    assign d_o = $unsigned(px) + $unsigned(py);

endmodule

// File: rtl/ghost_motion.sv
// Per-ghost position/direction controller with wall-map lookups.
// Define GHOST_WRAP_TUNNEL_EN to enable horizontal tunnel wrap.
module ghost_motion
    import ghost_pkg::*;
#(
    parameter logic [8:0] START_X   = 9'd104,
    parameter logic [8:0] START_Y   = 9'd112,
    parameter logic [1:0] START_DIR = 2'd1,
    parameter int         SPEED_DIV = 2,
    parameter int         X_MAX     = 224,
    parameter int         Y_MAX     = 288
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       frame_tick,
    input  logic [8:0] target_x,
    input  logic [8:0] target_y,
    output logic       wall_req,
    output logic [5:0] wall_tx,
    output logic [5:0] wall_ty,
    input  logic       wall_ack,
    input  logic       wall_is_wall,
    output logic [8:0] ghost_x,
    output logic [8:0] ghost_y,
    output logic [1:0] ghost_dir,
    output logic       busy
);

    localparam logic [5:0] XT       = 6'(X_MAX >> TILE_SHIFT);
    localparam logic [5:0] YT       = 6'(Y_MAX >> TILE_SHIFT);
    localparam logic [8:0] X_LAST   = 9'(X_MAX - 1);
    localparam logic [3:0] DIV_LAST = 4'(SPEED_DIV - 1);

    state_t            state_q, state_d;
    logic [8:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    dir_t              dir_q, dir_d;
    logic [3:0]        div_q, div_d;
    dir_t              cand_q, cand_d;
    logic              req_q, req_d;
    logic [5:0]        tx_q, tx_d;
    logic [5:0]        ty_q, ty_d;
    logic [3:0]        wall_q, wall_d;
    logic [3:0][12:0]  dist_q, dist_d;

    logic [5:0]  tile_x;
    logic [5:0]  tile_y;
    logic        aligned;
    dir_t        nc;
    tile_t       cur;
    tile_t       nxt;
    logic [12:0] cur_dist;
    dir_t        rev;
    logic        found;
    logic [12:0] best;
    dir_t        choice;
    logic        unused_lsb;

    function automatic tile_t nbr(input dir_t c, input logic [5:0] tx,
                                  input logic [5:0] ty);
        tile_t n;
        n.oob = 1'b0;
        n.tx  = tx;
        n.ty  = ty;
        case (c)
            UP: begin
                n.oob = (ty == 6'd0);
                n.ty  = ty - 6'd1;
            end
            DOWN: begin
                n.oob = (ty >= YT - 6'd1);
                n.ty  = ty + 6'd1;
            end
`ifdef GHOST_WRAP_TUNNEL_EN
            LEFT:  n.tx = (tx == 6'd0) ? XT - 6'd1 : tx - 6'd1;
            RIGHT: n.tx = (tx >= XT - 6'd1) ? 6'd0 : tx + 6'd1;
`else
            LEFT: begin
                n.oob = (tx == 6'd0);
                n.tx  = tx - 6'd1;
            end
            RIGHT: begin
                n.oob = (tx >= XT - 6'd1);
                n.tx  = tx + 6'd1;
            end
`endif
            default: n.oob = 1'b1;
        endcase
        return n;
    endfunction

    assign tile_x  = x_q[8:TILE_SHIFT];
    assign tile_y  = y_q[8:TILE_SHIFT];
    assign aligned = (x_q[2:0] == 3'd0) && (y_q[2:0] == 3'd0);
    assign nc      = (state_q == QUERY) ? dir_t'(cand_q + 2'd1) : UP;
    assign cur     = nbr(cand_q, tile_x, tile_y);
    assign nxt     = nbr(nc, tile_x, tile_y);
    assign unused_lsb = ^{target_x[2:0], target_y[2:0]};

    // One distance unit, pointed at whichever candidate is being resolved.
    ghost_dist_sq u_dist (
        .ax_i (cur.tx),
        .ay_i (cur.ty),
        .bx_i (target_x[8:TILE_SHIFT]),
        .by_i (target_y[8:TILE_SHIFT]),
        .d_o  (cur_dist)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= START_X;
            y_q     <= START_Y;
            dir_q   <= dir_t'(START_DIR);
            div_q   <= '0;
            cand_q  <= UP;
            req_q   <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            wall_q  <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            div_q   <= div_d;
            cand_q  <= cand_d;
            req_q   <= req_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            wall_q  <= wall_d;
            dist_q  <= dist_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        div_d   = div_q;
        cand_d  = cand_q;
        req_d   = req_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        wall_d  = wall_q;
        dist_d  = dist_q;
        rev     = reverse(dir_q);
        found   = 1'b0;
        best    = '0;
        choice  = dir_q;
        unique case (state_q)
            IDLE: begin
                if (en && frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (aligned) begin
                            state_d = QUERY;
                            cand_d  = UP;
                            req_d   = !nxt.oob;
                            if (!nxt.oob) begin
                                tx_d = nxt.tx;
                                ty_d = nxt.ty;
                            end
                        end else begin
                            state_d = MOVE;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            end
            QUERY: begin
                // Off-map candidates resolve as walls without a lookup.
                if (cur.oob || wall_ack) begin
                    wall_d[cand_q] = cur.oob || wall_is_wall;
                    dist_d[cand_q] = cur_dist;
                    if (cand_q == RIGHT) begin
                        state_d = DECIDE;
                        req_d   = 1'b0;
                    end else begin
                        cand_d = nc;
                        req_d  = !nxt.oob;
                        if (!nxt.oob) begin
                            tx_d = nxt.tx;
                            ty_d = nxt.ty;
                        end
                    end
                end
            end
            DECIDE: begin
                for (int c = 0; c < 4; c++) begin
                    if (!wall_q[c] && (c[1:0] != rev) &&
                        (!found || dist_q[c] < best)) begin
                        found  = 1'b1;
                        best   = dist_q[c];
                        choice = dir_t'(c[1:0]);
                    end
                end
                if (!found && !wall_q[rev]) begin
                    found  = 1'b1;
                    choice = rev;
                end
                if (found) begin
                    dir_d   = choice;
                    state_d = MOVE;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                state_d = IDLE;
                case (dir_q)
                    UP:   y_d = y_q - 9'd1;
                    DOWN: y_d = y_q + 9'd1;
`ifdef GHOST_WRAP_TUNNEL_EN
                    LEFT:  x_d = (x_q == 9'd0) ? X_LAST : x_q - 9'd1;
                    RIGHT: x_d = (x_q >= X_LAST) ? 9'd0 : x_q + 9'd1;
`else
                    LEFT:  x_d = x_q - 9'd1;
                    RIGHT: x_d = x_q + 9'd1;
`endif
                    default: x_d = x_q;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    assign wall_req  = req_q;
    assign wall_tx   = tx_q;
    assign wall_ty   = ty_q;
    assign ghost_x   = x_q;
    assign ghost_y   = y_q;
    assign ghost_dir = dir_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ghost_motion.sv
// Directed bench for ghost_motion: wall-map responder, move model,
// expected-position scoreboard.
module tb_ghost_motion;

    logic       clk;
    logic       rst;
    logic       en;
    logic       frame_tick;
    logic [8:0] target_x;
    logic [8:0] target_y;
    logic       wall_req;
    logic [5:0] wall_tx;
    logic [5:0] wall_ty;
    logic       wall_ack = 1'b0;
    logic       wall_is_wall = 1'b0;
    logic [8:0] ghost_x;
    logic [8:0] ghost_y;
    logic [1:0] ghost_dir;
    logic       busy;

    ghost_motion dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .frame_tick   (frame_tick),
        .target_x     (target_x),
        .target_y     (target_y),
        .wall_req     (wall_req),
        .wall_tx      (wall_tx),
        .wall_ty      (wall_ty),
        .wall_ack     (wall_ack),
        .wall_is_wall (wall_is_wall),
        .ghost_x      (ghost_x),
        .ghost_y      (ghost_y),
        .ghost_dir    (ghost_dir),
        .busy         (busy)
    );

    typedef struct {
        int x;
        int y;
        int d;
    } exp_t;

    exp_t sb[$];
    bit   wmap [64][64];
    int   checks = 0;
    int   failures = 0;
    int   mx, my, md;
    bit   ack_tie = 1'b1;
    int   ack_delay = 0;
    int   cnt = 0;
    int   hs = 0;
    int   unstable = 0;
    int   bad_tile = 0;
    bit   seen27 = 1'b0;
    logic pv_req = 1'b0;
    logic pv_ack = 1'b0;
    logic [5:0] pv_tx = '0;
    logic [5:0] pv_ty = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Wall-map responder and handshake monitor.
    always @(negedge clk) begin
        if (rst) begin
            wall_ack = 1'b0;
            cnt = 0;
            pv_req = 1'b0;
            pv_ack = 1'b0;
        end else begin
            if (wall_req && pv_req && !pv_ack &&
                (wall_tx != pv_tx || wall_ty != pv_ty))
                unstable++;
            if (wall_req && (wall_tx >= 6'd28 || wall_ty >= 6'd36))
                bad_tile++;
            if (ack_tie) begin
                wall_ack = 1'b1;
            end else if (wall_req) begin
                if (cnt == ack_delay) begin
                    wall_ack = 1'b1;
                    cnt = 0;
                end else begin
                    wall_ack = 1'b0;
                    cnt++;
                end
            end else begin
                wall_ack = 1'b0;
                cnt = 0;
            end
            wall_is_wall = wmap[wall_tx][wall_ty];
            if (wall_req && wall_ack) begin
                hs++;
                if (wall_tx == 6'd27 && wall_ty == 6'd14)
                    seen27 = 1'b1;
            end
            pv_req = wall_req;
            pv_ack = wall_ack;
            pv_tx  = wall_tx;
            pv_ty  = wall_ty;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int tx, ty, gx, gy, rv, bc;
        int nx[4];
        int ny[4];
        int dd[4];
        bit op[4];
        if (mx % 8 == 0 && my % 8 == 0) begin
            tx = mx / 8;
            ty = my / 8;
            gx = int'(target_x) / 8;
            gy = int'(target_y) / 8;
            nx = '{tx, tx - 1, tx, tx + 1};
            ny = '{ty - 1, ty, ty + 1, ty};
`ifdef GHOST_WRAP_TUNNEL_EN
            nx[1] = (nx[1] + 28) % 28;
            nx[3] = nx[3] % 28;
`endif
            for (int c = 0; c < 4; c++) begin
                op[c] = 1'b0;
                dd[c] = 0;
                if (nx[c] >= 0 && nx[c] < 28 && ny[c] >= 0 && ny[c] < 36) begin
                    op[c] = !wmap[nx[c]][ny[c]];
                    dd[c] = (nx[c] - gx) * (nx[c] - gx) +
                            (ny[c] - gy) * (ny[c] - gy);
                end
            end
            rv = md ^ 2;
            bc = -1;
            for (int c = 0; c < 4; c++)
                if (op[c] && c != rv && (bc < 0 || dd[c] < dd[bc]))
                    bc = c;
            if (bc < 0 && op[rv])
                bc = rv;
            if (bc < 0)
                return;
            md = bc;
        end
        case (md)
            0: my = my - 1;
            2: my = my + 1;
            1: mx = (mx == 0) ? 223 : mx - 1;
            default: mx = (mx == 223) ? 0 : mx + 1;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // mode 1: unaligned latency; mode 2: aligned zero-wait latency.
    task automatic step(input int n, input int mode);
        exp_t e;
        int ox, oy, od;
        ox = mx;
        oy = my;
        od = md;
        model_step();
        sb.push_back('{mx, my, md});
        repeat (n) tick();
        if (mode == 1) begin
            @(posedge clk);
            #1;
            chk("lat_k1_x", ghost_x, sb[0].x);
            chk("lat_k1_y", ghost_y, sb[0].y);
        end else if (mode == 2) begin
            repeat (4) @(posedge clk);
            #1;
            chk("lat_k4_dir", ghost_dir, od);
            @(posedge clk);
            #1;
            chk("lat_k5_dir", ghost_dir, sb[0].d);
            chk("lat_k5_y", ghost_y, oy);
            chk("lat_k5_x", ghost_x, ox);
            @(posedge clk);
            #1;
            chk("lat_k6_y", ghost_y, sb[0].y);
            chk("lat_k6_x", ghost_x, sb[0].x);
        end
        wait_idle();
        e = sb.pop_front();
        chk("sb_x", ghost_x, e.x);
        chk("sb_y", ghost_y, e.y);
        chk("sb_dir", ghost_dir, e.d);
    endtask

    task automatic walk_to(input int px, input int py);
        for (int g = 0; g < 300 && !(mx == px && my == py); g++)
            step(2, 0);
        chk("walk_x", ghost_x, px);
        chk("walk_y", ghost_y, py);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", ghost_x, 104);
        chk("rst_y", ghost_y, 112);
        chk("rst_dir", ghost_dir, 1);
        chk("rst_busy", busy, 0);
        chk("rst_req", wall_req, 0);
        chk("rst_tx", wall_tx, 0);
        chk("rst_ty", wall_ty, 0);
        @(negedge clk);
        rst = 1'b0;
        mx = 104;
        my = 112;
        md = 1;
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b1;
        frame_tick = 1'b0;
        target_x = 9'd104;
        target_y = 9'd32;
        apply_reset();

        // Junction: only RIGHT walled, target straight up.
        wmap[14][14] = 1'b1;
        step(2, 2);
        chk("junction_dir", ghost_dir, 0);
        chk("junction_y", ghost_y, 111);
        step(2, 1);
        chk("unaligned_y", ghost_y, 110);
        walk_to(104, 104);

        // Tie between LEFT and RIGHT with UP walled.
        wmap[13][12] = 1'b1;
        target_y = 9'd88;
        step(2, 2);
        chk("tie_dir", ghost_dir, 1);
        chk("tie_x", ghost_x, 103);
        walk_to(96, 104);

        target_x = 9'd96;
        target_y = 9'd0;
        step(2, 2);
        walk_to(96, 96);

        // Dead end: only the reverse is open.
        wmap[12][11] = 1'b1;
        wmap[11][12] = 1'b1;
        step(2, 2);
        chk("deadend_dir", ghost_dir, 2);
        chk("deadend_y", ghost_y, 97);
        walk_to(96, 104);

        // Fully boxed in: no move, direction kept.
        wmap[12][14] = 1'b1;
        wmap[11][13] = 1'b1;
        wmap[13][13] = 1'b1;
        wmap[12][12] = 1'b1;
        step(2, 0);
        chk("boxed_dir", ghost_dir, 2);
        chk("boxed_x", ghost_x, 96);
        chk("boxed_y", ghost_y, 104);

        // Delayed acks.
        wmap[12][14] = 1'b0;
        ack_tie = 1'b0;
        ack_delay = 3;
        hs = 0;
        step(2, 0);
        chk("hs_count", hs, 4);
        chk("hs_stable", unstable, 0);
        chk("hs_y", ghost_y, 105);

        // Reset during an outstanding lookup.
        apply_reset();
        tick();
        tick();
        @(posedge clk);
        #1;
        chk("midq_req_wait", wall_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midq_req", wall_req, 0);
        chk("midq_busy", busy, 0);
        chk("midq_x", ghost_x, 104);
        @(negedge clk);
        rst = 1'b0;
        ack_tie = 1'b1;

        // Disabled: ticks ignored, divider frozen.
        target_x = 9'd0;
        target_y = 9'd112;
        en = 1'b0;
        repeat (5) tick();
        chk("en0_x", ghost_x, 104);
        chk("en0_busy", busy, 0);
        en = 1'b1;
        tick();
        chk("div_frozen", busy, 0);
        step(1, 0);
        chk("en1_x", ghost_x, 103);

        // Tunnel edge at the left border.
        wmap[0][13] = 1'b1;
        wmap[0][15] = 1'b1;
        walk_to(0, 112);
        step(2, 0);
`ifdef GHOST_WRAP_TUNNEL_EN
        chk("tunnel_x", ghost_x, 223);
        chk("tunnel_dir", ghost_dir, 1);
        chk("tunnel_query", seen27, 1);
`else
        chk("edge_x", ghost_x, 1);
        chk("edge_dir", ghost_dir, 3);
`endif
        chk("tile_range", bad_tile, 0);
        chk("stable_all", unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
